// File: rtl/switch_bank_ctl_if.sv
// Host bus seen by the switch bank controller: chip enable, read strobe,
// register address and the shared tri-state data lines.
interface switch_bank_ctl_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 2
) ();
   logic              ce_n;
   logic              read_n;
   logic [ADDR_W-1:0] addr;
   wire  [WIDTH-1:0]  data;

   modport master (output ce_n, output read_n, output addr, input  data);
   modport slave  (input  ce_n, input  read_n, input  addr, output data);
endinterface

// File: rtl/switch_bank_ctl.sv
// Debounced multi-bank switch input controller.
// Each switch bit is synchronised, sampled on a prescaler tick into a
// three-deep history, and the debounced value follows once three equal
// samples disagree with it. Every debounced change latches a sticky flag;
// flags of a bank are cleared by reading that bank's flag register, but
// only the bits that were visible when the read began.
module switch_bank_ctl #(
   parameter int WIDTH           = 8,
   parameter int BANKS           = 2,
   parameter int ADDR_W          = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH*BANKS-1:0] switches,
   output logic                   irq,
   switch_bank_ctl_if.slave       bus
);

   localparam int N     = WIDTH * BANKS;
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [N-1:0]       sync1, sync2;
   logic [N-1:0]       hist0, hist1, hist2;
   logic [N-1:0]       deb, flags;
   logic [N-1:0]       upd, clr;
   logic [CNT_W-1:0]   pcnt;
   logic               tick;
   logic               rd_raw, rd_s1, rd_s2, rd_prev;
   logic               rd_rise, rd_fall;
   logic [ADDR_W-1:0]  cap_addr;
   logic [WIDTH-1:0]   snap;
   logic [WIDTH-1:0]   rd_val;

   assign tick    = (pcnt == CNT_W'(DEBOUNCE_CYCLES - 1));
   assign rd_raw  = ~(bus.ce_n | bus.read_n);
   assign rd_rise = rd_s2 & ~rd_prev;
   assign rd_fall = ~rd_s2 & rd_prev;

   // Two-flop synchroniser for every raw switch bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= switches;
         sync2 <= sync1;
      end
   end

   // Free-running prescaler; tick marks its terminal count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pcnt <= '0;
      else if (tick) pcnt <= '0;
      else pcnt <= pcnt + 1'b1;
   end

   // Shift the synchronised value into the sample history on each tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist0 <= '0;
         hist1 <= '0;
         hist2 <= '0;
      end else if (tick) begin
         hist0 <= sync2;
         hist1 <= hist0;
         hist2 <= hist1;
      end
   end

   // Bits whose three samples agree with each other but not with the debounced value.
   always_comb begin
      upd = (hist0 ~^ hist1) & (hist1 ~^ hist2) & (hist0 ^ deb);
   end

   // Debounced value follows the agreeing history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) deb <= '0;
      else deb <= (deb & ~upd) | (hist0 & upd);
   end

   // Read strobe synchroniser, edge history and capture of the flag snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_s1    <= 1'b0;
         rd_s2    <= 1'b0;
         rd_prev  <= 1'b0;
         cap_addr <= '0;
         snap     <= '0;
      end else begin
         rd_s1   <= rd_raw;
         rd_s2   <= rd_s1;
         rd_prev <= rd_s2;
         if (rd_rise) begin
            cap_addr <= bus.addr;
            snap     <= '0;
            for (int b = 0; b < BANKS; b++) begin
               if (int'(bus.addr) == BANKS + b) snap <= flags[b*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Clear mask: snapshot bits of the captured flag bank, at the end of the read.
   always_comb begin
      clr = '0;
      if (rd_fall) begin
         for (int b = 0; b < BANKS; b++) begin
            if (int'(cap_addr) == BANKS + b) clr[b*WIDTH +: WIDTH] = snap;
         end
      end
   end

   // Sticky change flags (a new change wins over a clear) and registered irq.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= '0;
         irq   <= 1'b0;
      end else begin
         flags <= (flags & ~clr) | upd;
         irq   <= |flags;
      end
   end

   // Register read mux: values first, then flags, anything else reads zero.
   always_comb begin
      rd_val = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (int'(bus.addr) == b)         rd_val = deb[b*WIDTH +: WIDTH];
         if (int'(bus.addr) == BANKS + b) rd_val = flags[b*WIDTH +: WIDTH];
      end
   end

   assign bus.data = rd_raw ? rd_val : {WIDTH{1'bz}};

endmodule

// File: tb/tb_switch_bank_ctl.sv
// Bench for switch_bank_ctl with WIDTH=8, BANKS=2, ADDR_W=2, DEBOUNCE_CYCLES=4.
module tb_switch_bank_ctl;
   localparam int W  = 8;
   localparam int B  = 2;
   localparam int AW = 2;
   localparam int D  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] switches = '0;
   logic        irq;
   logic        chk_on = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   int          lat;

   switch_bank_ctl_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   switch_bank_ctl #(.WIDTH(W), .BANKS(B), .ADDR_W(AW), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset(rst), .switches(switches), .irq(irq), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: edge count since reset, samples every D-th edge
   // of the input as it stood two edges earlier, keeps the last three samples.
   int          n;
   logic [15:0] p1, p2;
   logic        r1, r2, r3;
   logic [15:0] hq [3];
   logic [15:0] mdeb, mflags;
   logic        mirq;
   logic [1:0]  mcap;
   logic [7:0]  msnap;

   always @(posedge clk or posedge rst) begin
      logic [15:0] fb, chg, clrm;
      if (rst) begin
         n = 0; p1 = '0; p2 = '0; r1 = 0; r2 = 0; r3 = 0;
         for (int i = 0; i < 3; i++) hq[i] = '0;
         mdeb = '0; mflags = '0; mirq = 0; mcap = '0; msnap = '0;
      end else begin
         fb   = mflags;
         chg  = '0;
         for (int i = 0; i < 16; i++)
            if (hq[0][i] == hq[1][i] && hq[1][i] == hq[2][i] && hq[0][i] != mdeb[i]) begin
               chg[i]  = 1'b1;
               mdeb[i] = hq[0][i];
            end
         clrm = '0;
         if (!r2 && r3 && mcap >= 2) clrm[(mcap-2)*8 +: 8] = msnap;
         if (r2 && !r3) begin
            mcap  = bus.addr;
            msnap = (bus.addr >= 2) ? fb[(bus.addr-2)*8 +: 8] : 8'h00;
         end
         mflags = (fb & ~clrm) | chg;
         mirq   = (fb != 0);
         n++;
         if (n % D == 0) begin
            hq[2] = hq[1]; hq[1] = hq[0]; hq[0] = p2;
         end
         p2 = p1; p1 = switches;
         r3 = r2; r2 = r1; r1 = ~(bus.ce_n | bus.read_n);
      end
   end

   function automatic logic [7:0] model_sel(input logic [1:0] a);
      case (a)
         2'd0:    return mdeb[7:0];
         2'd1:    return mdeb[15:8];
         2'd2:    return mflags[7:0];
         default: return mflags[15:8];
      endcase
   endfunction

   // Per-cycle comparison of bus and irq against the model.
   always @(posedge clk) begin
      if (chk_on) begin
         #2;
         if (bus.ce_n | bus.read_n) check("bus_z", {15'd0, (bus.data === 8'hzz)}, 16'd1);
         else check("bus_data", {8'h00, bus.data}, {8'h00, model_sel(bus.addr)});
         check("irq", {15'd0, irq}, {15'd0, mirq});
      end
   end

   task automatic start_read(input logic [1:0] a);
      bus.addr = a; bus.ce_n = 1'b0; bus.read_n = 1'b0;
   endtask

   task automatic end_read();
      bus.ce_n = 1'b1; bus.read_n = 1'b1;
   endtask

   initial begin
      end_read();
      bus.addr = '0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      rst = 1'b0;

      // Reset state
      #1 check("idle_z", {15'd0, (bus.data === 8'hzz)}, 16'd1);
      check("rst_irq", {15'd0, irq}, 16'd0);
      for (int a = 0; a < 4; a++) begin
         @(negedge clk); start_read(2'(a));
         #1 check("rst_reg", {8'h00, bus.data}, 16'h0000);
      end
      @(negedge clk); bus.read_n = 1'b1;
      #1 check("z_read_n", {15'd0, (bus.data === 8'hzz)}, 16'd1);
      bus.ce_n = 1'b1; bus.read_n = 1'b0;
      #1 check("z_ce_n", {15'd0, (bus.data === 8'hzz)}, 16'd1);
      end_read();

      // Bank1 bit0 bouncing every 3 clk never debounces
      @(negedge clk); start_read(2'd1);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i % 3 == 0) switches[8] = ~switches[8];
      end
      switches[8] = 1'b0;
      repeat (20) @(negedge clk);
      check("bounce_val", {8'h00, bus.data}, 16'h0000);
      check("bounce_irq", {15'd0, irq}, 16'd0);
      bus.addr = 2'd3;
      #1 check("bounce_flag", {8'h00, bus.data}, 16'h0000);
      end_read();

      // Bank0 = 0xA5, watch debounce latency
      @(negedge clk); switches[7:0] = 8'hA5; start_read(2'd0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (lat == 0 && bus.data == 8'hA5) begin
            lat = i;
            check("irq_same_clk", {15'd0, irq}, 16'd0);
         end else if (lat != 0 && i == lat + 1) begin
            check("irq_next_clk", {15'd0, irq}, 16'd1);
         end
      end
      check("a5_latency_ok", {15'd0, (lat >= 11 && lat <= 16)}, 16'd1);
      check("addr0_a5", {8'h00, bus.data}, 16'h00A5);
      bus.addr = 2'd1;
      #1 check("addr1_zero", {8'h00, bus.data}, 16'h0000);
      bus.addr = 2'd3;
      #1 check("addr3_zero", {8'h00, bus.data}, 16'h0000);
      end_read();

      // 4-clk read of bank0 flags clears them
      @(negedge clk); start_read(2'd2);
      #1 check("addr2_a5", {8'h00, bus.data}, 16'h00A5);
      repeat (3) @(negedge clk);
      @(negedge clk); end_read();
      repeat (3) @(negedge clk);
      check("irq_before_fall", {15'd0, irq}, 16'd1);
      start_read(2'd2);
      #1 check("addr2_cleared", {8'h00, bus.data}, 16'h0000);
      @(negedge clk);
      check("irq_fell", {15'd0, irq}, 16'd0);
      bus.addr = 2'd0;
      #1 check("addr0_kept", {8'h00, bus.data}, 16'h00A5);
      end_read();

      // Bank1 bit0 high, then bit7 changes during a 10-clk flag read
      @(negedge clk); switches[15:8] = 8'h01;
      repeat (20) @(negedge clk);
      start_read(2'd1);
      #1 check("addr1_01", {8'h00, bus.data}, 16'h0001);
      end_read();
      @(negedge clk); switches[15] = 1'b1;
      repeat (7) @(negedge clk);
      start_read(2'd3);
      #1 check("addr3_start", {8'h00, bus.data}, 16'h0001);
      repeat (9) @(negedge clk);
      check("addr3_during", {8'h00, bus.data}, 16'h0081);
      end_read();
      repeat (4) @(negedge clk);
      start_read(2'd3);
      #1 check("addr3_after", {8'h00, bus.data}, 16'h0080);
      check("irq_kept", {15'd0, irq}, 16'd1);
      bus.addr = 2'd1;
      #1 check("addr1_81", {8'h00, bus.data}, 16'h0081);
      end_read();

      // Reset mid-debounce
      @(negedge clk); switches[7:0] = 8'hFF;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      for (int a = 0; a < 4; a++) begin
         start_read(2'(a));
         #1 check("rst_mid_reg", {8'h00, bus.data}, 16'h0000);
      end
      check("rst_mid_irq", {15'd0, irq}, 16'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0; start_read(2'd0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (lat == 0 && bus.data == 8'hFF) lat = i;
      end
      check("ff_latency", 16'(lat), 16'd13);
      end_read();
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
